// File: rtl/ofm_axi_wr_master.sv
// ofm_axi_wr_master
// -----------------
// Writes a request of wmst_xfer_size bytes, taken from a 512-bit stream,
// to memory at wmst_addr using AXI write bursts of up to MAX_BURST beats.
// Only one burst is outstanding at a time. wmst_done pulses once per request.
//
// Parameters
//   MAX_BURST  maximum beats per AXI burst (1..256)
//   WORD_BYTE  bytes per 512-bit beat
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   wmst_req/addr/xfer_size    one-cycle request pulse, base address, byte length
//   wmst_done                  one-cycle completion pulse
//   s_tdata/s_valid/s_ready    input data stream
//   m_axi_aw*                  AXI write address channel
//   m_axi_w*                   AXI write data channel (wstrb all ones)
//   m_axi_b*                   AXI write response channel
//   wr_err                     sticky error flag
//
// Build option
//   WR_RESP_ERR_EN  when defined, wr_err sets on any non-OKAY write response
//                   and clears only on reset; otherwise wr_err is tied low
//                   and bresp is ignored.
module ofm_axi_wr_master #(
    parameter int MAX_BURST = 16,
    parameter int WORD_BYTE = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wmst_req,
    input  logic [63:0]  wmst_addr,
    input  logic [63:0]  wmst_xfer_size,
    output logic         wmst_done,
    input  logic [511:0] s_tdata,
    input  logic         s_valid,
    output logic         s_ready,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    output logic [63:0]  m_axi_awaddr,
    output logic [7:0]   m_axi_awlen,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    output logic [511:0] m_axi_wdata,
    output logic [63:0]  m_axi_wstrb,
    output logic         m_axi_wlast,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready,
    input  logic [1:0]   m_axi_bresp,
    output logic         wr_err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [63:0]  cur_addr_r;
    logic [63:0]  beats_left_r;
    logic [8:0]   beat_cnt_r;

    logic [8:0]   burst_len_s;
    logic         last_beat_s;
    logic         w_hs_s;
    logic         b_hs_s;
    logic [63:0]  req_beats_s;
    logic [63:0]  beats_after_s;

    // Burst length derived from the remaining beats; beats_left_r is stable
    // throughout AW/W/B, so awlen and wlast see a constant value per burst.
    always_comb begin
        if (beats_left_r > 64'(MAX_BURST)) begin
            burst_len_s = 9'(MAX_BURST);
        end else begin
            burst_len_s = beats_left_r[8:0];
        end
    end

    assign last_beat_s   = (beat_cnt_r == (burst_len_s - 9'd1));
    assign w_hs_s        = (state_r == ST_W) && s_valid && m_axi_wready;
    assign b_hs_s        = (state_r == ST_B) && m_axi_bvalid;
    // Remainder bytes below one beat are intentionally dropped.
    assign req_beats_s   = wmst_xfer_size / 64'(WORD_BYTE);
    assign beats_after_s = beats_left_r - 64'(burst_len_s);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (wmst_req) begin
                    state_s = (req_beats_s == 64'd0) ? ST_DONE : ST_AW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_AW: begin
                if (m_axi_awready) begin
                    state_s = ST_W;
                end else begin
                    state_s = ST_AW;
                end
            end
            ST_W: begin
                if (w_hs_s && last_beat_s) begin
                    state_s = ST_B;
                end else begin
                    state_s = ST_W;
                end
            end
            ST_B: begin
                if (m_axi_bvalid) begin
                    state_s = (beats_after_s == 64'd0) ? ST_DONE : ST_AW;
                end else begin
                    state_s = ST_B;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Address / remaining-beat bookkeeping: latched on request, advanced per response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_r   <= 64'd0;
            beats_left_r <= 64'd0;
        end else if ((state_r == ST_IDLE) && wmst_req) begin
            cur_addr_r   <= wmst_addr;
            beats_left_r <= req_beats_s;
        end else if (b_hs_s) begin
            cur_addr_r   <= cur_addr_r + (64'(burst_len_s) * 64'(WORD_BYTE));
            beats_left_r <= beats_after_s;
        end else begin
            cur_addr_r   <= cur_addr_r;
            beats_left_r <= beats_left_r;
        end
    end

    // Beat counter within the current burst; rearmed while the address is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= 9'd0;
        end else begin
            case (state_r)
                ST_AW:   beat_cnt_r <= 9'd0;
                ST_W:    beat_cnt_r <= w_hs_s ? (beat_cnt_r + 9'd1) : beat_cnt_r;
                default: beat_cnt_r <= beat_cnt_r;
            endcase
        end
    end

    // Output decode; the data channel is a combinational pass-through during W only.
    always_comb begin
        m_axi_awvalid = 1'b0;
        m_axi_awaddr  = 64'd0;
        m_axi_awlen   = 8'd0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = 512'd0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_wstrb   = 64'hFFFF_FFFF_FFFF_FFFF;
        s_ready       = 1'b0;
        wmst_done     = 1'b0;
        case (state_r)
            ST_AW: begin
                m_axi_awvalid = 1'b1;
                m_axi_awaddr  = cur_addr_r;
                m_axi_awlen   = 8'(burst_len_s - 9'd1);
            end
            ST_W: begin
                m_axi_wvalid = s_valid;
                m_axi_wdata  = s_tdata;
                m_axi_wlast  = last_beat_s;
                s_ready      = m_axi_wready;
            end
            ST_B:    m_axi_bready = 1'b1;
            ST_DONE: wmst_done    = 1'b1;
            default: wmst_done    = 1'b0;
        endcase
    end

`ifdef WR_RESP_ERR_EN
    logic wr_err_r;

    // Sticky error flag: any accepted non-OKAY response sets it until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_r <= 1'b0;
        end else if (b_hs_s && (m_axi_bresp != 2'b00)) begin
            wr_err_r <= 1'b1;
        end else begin
            wr_err_r <= wr_err_r;
        end
    end

    assign wr_err = wr_err_r;
`else
    logic unused_bresp_s;

    assign unused_bresp_s = ^m_axi_bresp;
    assign wr_err         = 1'b0;
`endif

endmodule

// File: doc/ofm_axi_wr_master.md
OFM_AXI_WR_MASTER -- requirements
Module: ofm_axi_wr_master

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16: maximum beats per AXI burst, 1..256.
REQ-002 SHALL have parameter WORD_BYTE, default 64: bytes per 512-bit beat.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 wmst_req  in  1  one-cycle write request pulse.
REQ-007 wmst_addr  in  64  request base byte address, WORD_BYTE-aligned.
REQ-008 wmst_xfer_size  in  64  request length in bytes.
REQ-009 wmst_done  out  1  one-cycle request-complete pulse.
REQ-010 s_tdata  in  512  write data stream.
REQ-011 s_valid  in  1  stream data valid.
REQ-012 s_ready  out  1  stream data accepted.
REQ-013 m_axi_awvalid  out  1  write address valid.
REQ-014 m_axi_awready  in  1  write address ready.
REQ-015 m_axi_awaddr  out  64  burst start byte address.
REQ-016 m_axi_awlen  out  8  burst beats minus one.
REQ-017 m_axi_wvalid  out  1  write data valid.
REQ-018 m_axi_wready  in  1  write data ready.
REQ-019 m_axi_wdata  out  512  write data.
REQ-020 m_axi_wstrb  out  64  byte strobes, always all ones.
REQ-021 m_axi_wlast  out  1  last beat of burst.
REQ-022 m_axi_bvalid  in  1  write response valid.
REQ-023 m_axi_bready  out  1  write response ready.
REQ-024 m_axi_bresp  in  2  write response code.
REQ-025 wr_err  out  1  sticky write-error flag (see Configuration).

Function
REQ-026 FSM states SHALL be IDLE, AW, W, B, DONE; one burst outstanding at a time.
REQ-027 In IDLE, wmst_req high SHALL latch cur_addr=wmst_addr and beats_left=wmst_xfer_size/WORD_BYTE (remainder bits ignored) and go to AW; if beats_left=0, go to DONE with no AXI traffic.
REQ-028 wmst_req outside IDLE SHALL be ignored.
REQ-029 On entering AW, burst_len SHALL be min(beats_left, MAX_BURST); m_axi_awlen=burst_len-1; m_axi_awaddr=cur_addr.
REQ-030 In AW, m_axi_awvalid SHALL be 1 with awaddr/awlen held stable until awready; on handshake go to W.
REQ-031 In W, m_axi_wvalid=s_valid, s_ready=m_axi_wready, m_axi_wdata=s_tdata (combinational); s_ready SHALL be 0 in every other state.
REQ-032 A beat counter SHALL advance on wvalid&wready; m_axi_wlast SHALL be 1 exactly on beat burst_len-1; after that handshake go to B.
REQ-033 In B, m_axi_bready SHALL be 1; on bvalid: cur_addr+=burst_len*WORD_BYTE, beats_left-=burst_len; go to DONE if beats_left=0, else AW.
REQ-034 DONE SHALL assert wmst_done for exactly one cycle, then return to IDLE; next wmst_req is accepted in that IDLE cycle.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, clear counters/address registers, drive all outputs 0 (wstrb excepted: all ones), including mid-burst; no completion of the aborted burst.

Configuration
REQ-036 Macro WR_RESP_ERR_EN defined: wr_err SHALL set on any accepted response with bresp!=2'b00 and clear only on reset; undefined: wr_err tied 0, bresp ignored; protocol behaviour otherwise identical.

Verification
REQ-037 req addr 0x1000 size 128, ready always 1 -> one AW awaddr 0x1000 awlen 1, two W beats, wlast on beat 2, wmst_done one cycle after B handshake.
REQ-038 req addr 0x0 size 2560 (40 beats) -> bursts awlen 15/15/7 at 0x0/0x400/0x800, exactly one wmst_done.
REQ-039 size 256, wready toggling 1/0 and s_valid gaps -> data in order, no beat lost or duplicated, s_ready mirrors wready only in W.
REQ-040 size 0 -> no awvalid, wmst_done pulses within 2 cycles of request.
REQ-041 rst_n low during W beat 3 of 16 -> all outputs 0 next instant; fresh request after reset completes normally.
REQ-042 WR_RESP_ERR_EN defined, bresp=2'b10 -> wr_err=1, held through later OKAY responses until reset; undefined -> wr_err stays 0.
